// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared constants for the host-side debug loader and its byte assembler:
// data/byte widths, default instruction address width, command byte codes,
// the end-of-program instruction word, and the loader state encoding.
// -----------------------------------------------------------------------------
package debug_pkg;

  localparam int NB_DATA          = 32;
  localparam int NB_BYTE          = 8;
  localparam int NB_IADDR_DEFAULT = 8;

  localparam logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [NB_BYTE-1:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [NB_BYTE-1:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [NB_BYTE-1:0] CMD_STOP = 8'h48;  // 'H'

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } state_e;

endpackage

// File: rtl/byte2word_assembler.sv
// -----------------------------------------------------------------------------
// byte2word_assembler
// Packs a stream of bytes into little-endian words (first byte -> [7:0]).
// When the last lane of a word is captured, the completed word is latched
// into a separate output register and o_word_valid pulses for one cycle in
// the following cycle. Because the partial word and the output word are
// distinct registers, a byte arriving during that pulse starts the next word
// without disturbing the one being presented.
//
// Ports:
//   clk          in   clock, rising edge
//   i_rst        in   asynchronous reset, active-high
//   i_clear      in   restart assembly at lane 0 (partial word discarded)
//   i_rx_valid   in   i_rx_data holds a byte to capture
//   i_rx_data    in   byte to capture
//   o_word       out  last completed word (held until the next one)
//   o_word_valid out  one-cycle pulse: o_word was just completed
// -----------------------------------------------------------------------------
module byte2word_assembler
  import debug_pkg::*;
#(
  parameter int W_DATA = NB_DATA,
  parameter int W_BYTE = NB_BYTE
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_rx_valid,
  input  logic [W_BYTE-1:0] i_rx_data,
  output logic [W_DATA-1:0] o_word,
  output logic              o_word_valid
);

  localparam int                N_LANES = W_DATA / W_BYTE;
  localparam int                NB_CNT  = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [NB_CNT-1:0] LAST    = NB_CNT'(N_LANES - 1);

  logic [NB_CNT-1:0] cnt_q;
  logic [W_DATA-1:0] partial_q, partial_d;
  logic [W_DATA-1:0] word_q;
  logic              word_valid_q;

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    partial_d = partial_q;
    if (i_rx_valid) begin
      partial_d[int'(cnt_q) * W_BYTE +: W_BYTE] = i_rx_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q        <= '0;
      partial_q    <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= 1'b0;
      if (i_clear) begin
        cnt_q     <= '0;
        partial_q <= '0;
      end else if (i_rx_valid) begin
        partial_q <= partial_d;
        if (cnt_q == LAST) begin
          cnt_q        <= '0;
          word_q       <= partial_d;
          word_valid_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign o_word       = word_q;
  assign o_word_valid = word_valid_q;

endmodule

// File: rtl/debug_loader.sv
// -----------------------------------------------------------------------------
// debug_loader
// Host-side initiator for program load and halt control of the pipeline.
// Decodes one-byte UART commands: 'L' loads little-endian instruction words
// into the IF instruction memory until HALT_WORD is written (or the memory is
// full), 'R' free-runs until the pipeline reports halt or 'H' arrives, and
// 'S' releases the pipeline for exactly one cycle. All outputs are registered.
//
// Ports:
//   clk                 in   clock, rising edge
//   i_rst               in   asynchronous reset, active-high
//   i_rx_valid          in   one-cycle strobe: i_rx_data holds a new byte
//   i_rx_data           in   received byte
//   i_halt_reached      in   pipeline has retired HALT_WORD
//   o_we_IF             out  instruction-memory write strobe
//   o_instruction_data  out  word to write
//   o_instr_addr        out  word index of the current write
//   o_halt              out  pipeline freeze, 1 = frozen
//   o_load_done         out  a HALT_WORD-terminated program is loaded
//   o_busy              out  FSM not in IDLE
//   o_run_done          out  one-cycle pulse: RUN or STEP finished
//   o_error             out  one-cycle pulse: protocol error
// -----------------------------------------------------------------------------
module debug_loader
  import debug_pkg::*;
#(
  parameter int NB_IADDR = NB_IADDR_DEFAULT
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_rx_valid,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_halt_reached,
  output logic                o_we_IF,
  output logic [NB_DATA-1:0]  o_instruction_data,
  output logic [NB_IADDR-1:0] o_instr_addr,
  output logic                o_halt,
  output logic                o_load_done,
  output logic                o_busy,
  output logic                o_run_done,
  output logic                o_error
);

  localparam logic [NB_IADDR-1:0] ADDR_LAST = '1;

  state_e              state_q;
  logic [NB_IADDR-1:0] addr_q;
  logic                halt_q, load_done_q, busy_q, run_done_q, error_q;

  logic               asm_clear, asm_valid, word_valid;
  logic [NB_DATA-1:0] word;

  // Bytes only reach the assembler while loading; 'L' restarts it at lane 0.
  assign asm_clear = (state_q == ST_IDLE) && i_rx_valid && (i_rx_data == CMD_LOAD);
  assign asm_valid = (state_q == ST_LOAD) && i_rx_valid;

  byte2word_assembler #(
    .W_DATA (NB_DATA),
    .W_BYTE (NB_BYTE)
  ) u_asm (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_clear      (asm_clear),
    .i_rx_valid   (asm_valid),
    .i_rx_data    (i_rx_data),
    .o_word       (word),
    .o_word_valid (word_valid)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      halt_q      <= 1'b1;
      load_done_q <= 1'b0;
      busy_q      <= 1'b0;
      run_done_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      run_done_q <= 1'b0;
      error_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_LOAD: begin
                state_q     <= ST_LOAD;
                busy_q      <= 1'b1;
                addr_q      <= '0;
                load_done_q <= 1'b0;
              end
              CMD_RUN, CMD_STEP: begin
                if (load_done_q) begin
                  state_q <= (i_rx_data == CMD_RUN) ? ST_RUN : ST_STEP;
                  busy_q  <= 1'b1;
                  halt_q  <= 1'b0;
                end else begin
                  error_q <= 1'b1;
                end
              end
              default: error_q <= 1'b1;
            endcase
          end
        end
        ST_LOAD: begin
          // word_valid coincides with o_we_IF; addr_q is still the write address.
          if (word_valid) begin
            addr_q <= addr_q + 1'b1;
            if (word == HALT_WORD) begin
              load_done_q <= 1'b1;
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
            end else if (addr_q == ADDR_LAST) begin
              error_q <= 1'b1;
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (i_halt_reached || (i_rx_valid && (i_rx_data == CMD_STOP))) begin
            halt_q     <= 1'b1;
            run_done_q <= 1'b1;
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
          end
        end
        ST_STEP: begin
          // The single released cycle is this one; freeze again next cycle.
          halt_q     <= 1'b1;
          run_done_q <= 1'b1;
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
        end
        default: begin
          halt_q  <= 1'b1;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_we_IF            = word_valid;
  assign o_instruction_data = word;
  assign o_instr_addr       = addr_q;
  assign o_halt             = halt_q;
  assign o_load_done        = load_done_q;
  assign o_busy             = busy_q;
  assign o_run_done         = run_done_q;
  assign o_error            = error_q;

endmodule

// File: doc/debug_loader.md
Name: debug_loader

Overview:
- Host-side initiator for the pipeline's instruction-load and halt controls.
- Consumes the byte stream from the UART receiver.
- Decodes one-byte commands and assembles little-endian 32-bit instruction words.
- Drives the pipeline's IF write port (i_we_IF / i_instruction_data), then sequences i_halt for free-run and single-step execution.

Parameters:
NB_DATA  32  instruction word width
NB_BYTE  8  UART byte width
NB_IADDR  8  instruction word-address width; capacity 2**NB_IADDR words
HALT_WORD  32'hFFFF_FFFF  end-of-program instruction encoding
CMD_LOAD  8'h4C  'L': start program load
CMD_RUN  8'h52  'R': free-run until halt reached
CMD_STEP  8'h53  'S': execute one cycle
CMD_STOP  8'h48  'H': abort a free-run

Ports:
clk  in  1  system clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_rx_valid  in  1  one-cycle strobe: i_rx_data holds a new byte
i_rx_data  in  8  received byte
i_halt_reached  in  1  pipeline has retired HALT_WORD (level or pulse)
o_we_IF  out  1  instruction-memory write strobe to pipeline
o_instruction_data  out  32  word to write
o_instr_addr  out  NB_IADDR  word index of current write
o_halt  out  1  pipeline freeze; 1 = frozen
o_load_done  out  1  valid program (terminated by HALT_WORD) is loaded
o_busy  out  1  FSM not in IDLE
o_run_done  out  1  one-cycle pulse: RUN or STEP completed
o_error  out  1  one-cycle pulse: protocol error

Behaviour:
- Interface: one clock clk; reset i_rst asynchronous, active-high.
- Reset values:
  - o_halt=1.
  - All other outputs 0.
  - State IDLE; byte counter 0; address 0; partial word cleared.
- Reset mid-operation discards the partial word and clears o_load_done.
- States: IDLE, LOAD, RUN, STEP.
- IDLE, on i_rx_valid:
  - CMD_LOAD: go to LOAD; clear address, byte counter and o_load_done.
  - CMD_RUN with o_load_done=1: go to RUN.
  - CMD_STEP with o_load_done=1: go to STEP.
  - CMD_RUN or CMD_STEP with o_load_done=0: o_error pulse next cycle; stay in IDLE.
  - Any other byte: o_error pulse; stay in IDLE.
- LOAD, byte assembly:
  - Each valid byte goes to lane byte_cnt (byte 0 is [7:0], byte 3 is [31:24]); byte_cnt wraps 3->0.
  - The cycle after the 4th byte, o_we_IF=1 for exactly one cycle, with o_instruction_data=word and o_instr_addr=current address.
  - The address then increments.
  - The write strobe is registered and independent of byte capture. A byte arriving in the write cycle is captured as byte 0 of the next word; no byte is ever dropped.
- LOAD, termination:
  - Written word == HALT_WORD: o_load_done=1, return to IDLE in the same cycle as the write.
  - Write to address 2**NB_IADDR-1 that is not HALT_WORD: o_error pulse, o_load_done stays 0, return to IDLE. The address wraps but no further writes occur.
  - Command bytes inside LOAD are data, not commands.
- RUN:
  - o_halt=0 from the cycle after the command is accepted.
  - On i_halt_reached=1 or a CMD_STOP byte: o_halt=1 next cycle, o_run_done pulse, go to IDLE.
  - If both occur in the same cycle, a single o_run_done pulse is issued.
  - Other bytes are ignored.
- STEP:
  - o_halt=0 for exactly one cycle, then 1.
  - o_run_done pulses in the cycle o_halt returns to 1; go to IDLE.
  - Bytes received during STEP are ignored.
- Outputs:
  - o_halt is 1 in IDLE and LOAD.
  - o_busy = (state != IDLE).
  - All outputs are registered.
- Latency: a command byte to the first effect on o_halt is 1 cycle.

Decomposition:
- Shared package debug_pkg:
  - command byte constants (CMD_*), HALT_WORD;
  - state enumeration localparams (IDLE/LOAD/RUN/STEP);
  - NB_IADDR default.
- Sub-module byte2word_assembler:
  - inputs i_rx_valid, i_rx_data, a clear;
  - outputs a 32-bit word and a one-cycle word_valid.
  - It is reused by the planned data-memory readback path.

Test Plan:
- Reset with i_rst pulsed asynchronously mid-cycle -> o_halt=1, o_we_IF=0, o_load_done=0, o_busy=0 immediately.
- 'L', then bytes 78 56 34 12, then FF FF FF FF -> write of 32'h12345678 at addr 0, write of 32'hFFFFFFFF at addr 1; o_load_done=1; exactly 2 o_we_IF pulses.
- Back-to-back bytes (i_rx_valid held high 8 cycles) after 'L' -> both words written correctly; the byte in each write cycle is not lost.
- 'R' before any load -> o_error single pulse, o_halt stays 1. After a valid load, 'R' -> o_halt=0 next cycle. i_halt_reached high for 1 cycle -> o_halt=1 next cycle and o_run_done pulse.
- After load, 'S' three times -> exactly three single-cycle o_halt=0 windows, three o_run_done pulses. 'H' during RUN -> halt and o_run_done.
- NB_IADDR=2, load 4 non-HALT words -> 4 writes at addr 0..3, o_error pulse, o_load_done=0. Reset asserted after byte 2 of a word -> no write, state IDLE.
